axis_master_fifo: RTL and testbench

Parametrised AXI4-Stream master with an internal synchronous FIFO and a registered output stage. Accepts words, keep bytes and end-of-packet markers from internal datapath logic. Drives them onto an AXI4-Stream master port with full protocol-correct backpressure: TVALID never waits for TREADY, and data holds stable while stalled. Also exposes fill level, upstream ready, a sticky overflow flag and an output packet counter for the DMA/control logic above it.

---
 rtl/axis_pkg.sv | 31 +++
 rtl/axis_sync_fifo.sv | 62 ++++++
 rtl/axis_master_fifo.sv | 113 +++++++++++
 tb/tb_axis_master_fifo.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream master FIFO: width derivations and the
// beat layout {TLAST, TKEEP, TDATA} used for FIFO storage.
package axis_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int keep_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int beat_width(input int data_w);
    return data_w + keep_width(data_w) + 1;
  endfunction

  localparam int DEFAULT_TDATA_W = 32;
  localparam int DEFAULT_BEAT_W  = DEFAULT_TDATA_W + DEFAULT_TDATA_W / 8 + 1;

  typedef struct packed {
    logic                         last;
    logic [DEFAULT_TDATA_W/8-1:0] keep;
    logic [DEFAULT_TDATA_W-1:0]   data;
  } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO storage with extra-MSB pointers. The not-full flag is
// registered from the next-state pointers so it never depends combinationally on inputs.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_not_full,
  output logic             o_empty
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_not_full;

  logic             w_wr;
  logic             w_rd;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic             w_full_nxt;

  assign o_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_wr         = i_wr_en && r_not_full;
  assign w_rd         = i_rd_en && !o_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd);

  // Full when the wrap bits differ but the addresses coincide.
  assign w_full_nxt = (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                      (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_not_full <= 1'b1;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_not_full <= !w_full_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_not_full = r_not_full;

endmodule

// File: rtl/axis_master_fifo.sv
// AXI4-Stream master: FIFO array plus a registered output stage, with fill
// level, sticky overflow and a sent-packet counter for the control logic above.
module axis_master_fifo
  import axis_pkg::*;
#(
  parameter int FIFO_DEPTH           = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_CNT_WIDTH        = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   TDATA_in,
  input  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] TKEEP_in,
  input  logic                              TLAST_in,
  input  logic                              TVALID_in,
  output logic                              TREADY_out,
  input  logic                              CLR_OVF,
  input  logic                              M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  output logic [clog2(FIFO_DEPTH+1):0]      LEVEL,
  output logic                              OVERFLOW,
  output logic [PKT_CNT_WIDTH-1:0]          PKT_CNT
);

  localparam int KEEP_W  = keep_width(C_M_AXIS_TDATA_WIDTH);
  localparam int BEAT_W  = beat_width(C_M_AXIS_TDATA_WIDTH);
  localparam int LEVEL_W = clog2(FIFO_DEPTH + 1) + 1;

  // Handshake rule on both sides: a beat transfers on a rising edge where
  // valid && ready. The source raises valid without waiting for ready and holds
  // the beat stable until it transfers; upstream writes while not ready are dropped.

  logic                            w_not_full;
  logic                            w_empty;
  logic                            w_wr_acc;
  logic                            w_fire;
  logic                            w_load;
  logic [BEAT_W-1:0]               w_wr_beat;
  logic [BEAT_W-1:0]               w_rd_beat;

  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_tdata;
  logic [KEEP_W-1:0]               r_tkeep;
  logic                            r_tlast;
  logic                            r_tvalid;
  logic [LEVEL_W-1:0]              r_level;
  logic                            r_ovf;
  logic [PKT_CNT_WIDTH-1:0]        r_pkt_cnt;

  assign w_wr_beat = {TLAST_in, TKEEP_in, TDATA_in};
  assign w_wr_acc  = TVALID_in && w_not_full;
  assign w_fire    = r_tvalid && M_AXIS_TREADY;
  assign w_load    = !w_empty && (!r_tvalid || M_AXIS_TREADY);

  axis_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .i_clk      (M_AXIS_ACLK),
    .i_rst_n    (M_AXIS_ARESETN),
    .i_wr_en    (TVALID_in),
    .i_wr_data  (w_wr_beat),
    .i_rd_en    (w_load),
    .o_rd_data  (w_rd_beat),
    .o_not_full (w_not_full),
    .o_empty    (w_empty)
  );

  // Output stage refills on the same edge that retires the current beat.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tkeep  <= '0;
      r_tdata  <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_rd_beat[BEAT_W-1];
      r_tkeep  <= w_rd_beat[BEAT_W-2 -: KEEP_W];
      r_tdata  <= w_rd_beat[C_M_AXIS_TDATA_WIDTH-1:0];
    end else if (w_fire) begin
      r_tvalid <= 1'b0;
    end
  end

  // Level counts words in the whole block; an array-to-register move is neutral.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_level <= r_level + LEVEL_W'(w_wr_acc) - LEVEL_W'(w_fire);
      if (TVALID_in && !w_not_full) r_ovf <= 1'b1;
      else if (CLR_OVF)             r_ovf <= 1'b0;
      if (w_fire && r_tlast) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign TREADY_out    = w_not_full;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TKEEP  = r_tkeep;
  assign M_AXIS_TSTRB  = r_tkeep;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TVALID = r_tvalid;
  assign LEVEL         = r_level;
  assign OVERFLOW      = r_ovf;
  assign PKT_CNT       = r_pkt_cnt;

endmodule

// File: tb/tb_axis_master_fifo.sv
// Directed bench for axis_master_fifo: reset, latency, fill/overflow, stall,
// random backpressure against a scoreboard, mid-packet reset and counter wrap.
module tb_axis_master_fifo;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int BW = DW + KW + 1;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tdata_in;
  logic [KW-1:0] tkeep_in;
  logic          tlast_in;
  logic          tvalid_in;
  logic          tready_out;
  logic          clr_ovf;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [KW-1:0] m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic [LW-1:0] level;
  logic          ovf;
  logic [15:0]   pkt_cnt;

  logic [DW-1:0] w4_tdata_in;
  logic          w4_tvalid_in;
  logic          w4_tready_out;
  logic [DW-1:0] w4_tdata;
  logic [KW-1:0] w4_tkeep;
  logic [KW-1:0] w4_tstrb;
  logic          w4_tlast;
  logic          w4_tvalid;
  logic [LW-1:0] w4_level;
  logic          w4_ovf;
  logic [3:0]    w4_pkt_cnt;

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  axis_master_fifo u_dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .TDATA_in       (tdata_in),
    .TKEEP_in       (tkeep_in),
    .TLAST_in       (tlast_in),
    .TVALID_in      (tvalid_in),
    .TREADY_out     (tready_out),
    .CLR_OVF        (clr_ovf),
    .M_AXIS_TREADY  (m_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TKEEP   (m_tkeep),
    .M_AXIS_TSTRB   (m_tstrb),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TVALID  (m_tvalid),
    .LEVEL          (level),
    .OVERFLOW       (ovf),
    .PKT_CNT        (pkt_cnt)
  );

  axis_master_fifo #(.PKT_CNT_WIDTH(4)) u_dut4 (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .TDATA_in       (w4_tdata_in),
    .TKEEP_in       (4'hF),
    .TLAST_in       (1'b1),
    .TVALID_in      (w4_tvalid_in),
    .TREADY_out     (w4_tready_out),
    .CLR_OVF        (1'b0),
    .M_AXIS_TREADY  (1'b1),
    .M_AXIS_TDATA   (w4_tdata),
    .M_AXIS_TKEEP   (w4_tkeep),
    .M_AXIS_TSTRB   (w4_tstrb),
    .M_AXIS_TLAST   (w4_tlast),
    .M_AXIS_TVALID  (w4_tvalid),
    .LEVEL          (w4_level),
    .OVERFLOW       (w4_ovf),
    .PKT_CNT        (w4_pkt_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted writes, score the beat leaving this cycle,
  // then advance to 1 time unit past the next rising edge.
  task automatic cycle();
    logic [BW-1:0] beat;
    if (tvalid_in && tready_out) exp_q.push_back({tlast_in, tkeep_in, tdata_in});
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("sb_beat_expected", 64'(m_tvalid && m_tready && exp_q.size() != 0), 64'd1);
      end else begin
        beat = exp_q.pop_front();
        check("sb_beat", {m_tlast, m_tkeep, m_tdata}, beat);
        check("sb_tstrb", m_tstrb, beat[BW-2 -: KW]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int n;
    int written;
    int pkts;
    int pkt_left;
    int cyc;
    logic accepted;
    logic [DW-1:0] wdata;

    rst_n = 1'b0;
    tdata_in = '0; tkeep_in = '0; tlast_in = 1'b0; tvalid_in = 1'b0;
    clr_ovf = 1'b0; m_tready = 1'b0;
    w4_tdata_in = '0; w4_tvalid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tkeep", m_tkeep, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tready_out", tready_out, 1);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_w4_pkt_cnt", w4_pkt_cnt, 0);
    rst_n = 1'b1;
    cycle();
    check("idle_tvalid", m_tvalid, 0);
    check("idle_level", level, 0);

    // Single-beat latency
    m_tready = 1'b1;
    tdata_in = 32'hA5A5_0001; tkeep_in = 4'hF; tlast_in = 1'b1; tvalid_in = 1'b1;
    cycle();
    tvalid_in = 1'b0; tlast_in = 1'b0;
    check("lat_k_tvalid", m_tvalid, 0);
    check("lat_k_level", level, 1);
    cycle();
    check("lat_k1_tvalid", m_tvalid, 1);
    check("lat_k1_tdata", m_tdata, 32'hA5A5_0001);
    check("lat_k1_tkeep", m_tkeep, 4'hF);
    check("lat_k1_tstrb", m_tstrb, 4'hF);
    check("lat_k1_tlast", m_tlast, 1);
    check("lat_k1_level", level, 1);
    cycle();
    check("lat_done_tvalid", m_tvalid, 0);
    check("lat_done_pkt_cnt", pkt_cnt, 1);
    check("lat_done_level", level, 0);
    check("lat_done_queue", exp_q.size(), 0);

    // Fill 17 words with downstream stalled
    m_tready = 1'b0;
    tkeep_in = 4'hF;
    for (int i = 0; i < 17; i++) begin
      tdata_in = 32'h100 + i;
      tlast_in = (i == 16);
      tvalid_in = 1'b1;
      if (i == 16) check("fill_ready_before_17th", tready_out, 1);
      cycle();
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    check("fill_tready_out", tready_out, 0);
    check("fill_level", level, 17);
    check("fill_tvalid", m_tvalid, 1);
    check("fill_tdata", m_tdata, 32'h100);
    check("fill_ovf", ovf, 0);
    tdata_in = 32'hDEAD_BEEF; tvalid_in = 1'b1;
    cycle();
    tvalid_in = 1'b0;
    check("drop_ovf", ovf, 1);
    check("drop_level", level, 17);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("clr_ovf", ovf, 0);
    tvalid_in = 1'b1; clr_ovf = 1'b1;
    cycle();
    tvalid_in = 1'b0; clr_ovf = 1'b0;
    check("ovf_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("clr_ovf_again", ovf, 0);

    // Stall: output beat must hold
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_tvalid", m_tvalid, 1);
      check("stall_tdata", m_tdata, 32'h100);
      check("stall_tkeep", m_tkeep, 4'hF);
      check("stall_tlast", m_tlast, 0);
    end
    m_tready = 1'b1;
    drain(n);
    check("drain_cycles", n, 17);
    check("drain_tvalid", m_tvalid, 0);
    check("drain_level", level, 0);
    check("drain_pkt_cnt", pkt_cnt, 2);
    check("drain_tready_out", tready_out, 1);

    // Continuous writes with random backpressure
    written = 0; pkts = 0; cyc = 0;
    wdata = 32'h1000_0000;
    pkt_left = $urandom_range(1, 7);
    while (written < 1000 && cyc < 5000) begin
      m_tready = ($urandom_range(0, 3) != 0);
      if (tready_out) begin
        tvalid_in = 1'b1;
        tdata_in  = wdata;
        tkeep_in  = 4'($urandom_range(1, 15));
        tlast_in  = (pkt_left == 1) || (written == 999);
      end else begin
        tvalid_in = 1'b0;
      end
      accepted = tvalid_in;
      cycle();
      cyc++;
      if (accepted) begin
        written++;
        wdata++;
        if (tlast_in) begin
          pkts++;
          pkt_left = $urandom_range(1, 7);
        end else begin
          pkt_left--;
        end
      end
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    check("rand_written", written, 1000);
    m_tready = 1'b1;
    drain(n);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_pkt_cnt", pkt_cnt, 2 + pkts);
    check("rand_level", level, 0);
    check("rand_ovf", ovf, 0);
    check("rand_tvalid", m_tvalid, 0);

    // Reset in the middle of a packet at level 9
    m_tready = 1'b0;
    tkeep_in = 4'h3;
    for (int i = 0; i < 9; i++) begin
      tdata_in = 32'h300 + i; tlast_in = 1'b0; tvalid_in = 1'b1;
      cycle();
    end
    tvalid_in = 1'b0;
    check("mid_level", level, 9);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_tready_out", tready_out, 1);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    exp_q.delete();
    rst_n = 1'b1;
    cycle();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tdata_in = 32'h200 + i; tkeep_in = 4'h3; tlast_in = (i == 2); tvalid_in = 1'b1;
      cycle();
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    drain(n);
    cycle();
    check("post_rst_queue", exp_q.size(), 0);
    check("post_rst_pkt_cnt", pkt_cnt, 1);
    check("post_rst_level", level, 0);
    check("post_rst_tvalid", m_tvalid, 0);

    // 4-bit packet counter wraps after 16 packets
    w4_tvalid_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w4_tdata_in = 32'(i);
      cycle();
    end
    w4_tvalid_in = 1'b0;
    repeat (3) cycle();
    check("w4_pkt_cnt_wrap", w4_pkt_cnt, 4'd1);
    check("w4_level", w4_level, 0);
    check("w4_ovf", w4_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
